// File: rtl/spi_bootfetch.sv
// spi_bootfetch
// Boot-image fetch sequencer in front of the microSDHC SPI core. After a start
// pulse it initialises the card, issues one CMD17 per sector and streams the
// 128 32-bit words of each sector into a target memory write port.
//
// Ports:
//   spi_clk_i        system clock (rising edge)
//   spi_rst_i        asynchronous active-low reset
//   boot_start_i     start pulse, honoured only in IDLE
//   spi_initdone_i   card initialisation complete (level)
//   spi_flagreg_i    [0] R1 valid, [1] data word valid, [2] core data error
//   spi_data_i       word from the core; [7:0] is R1 when flag[0] is set
//   spi_init_o       one-cycle card-init request
//   spi_enableoper_o one-cycle command launch
//   spi_cmd_o        48-bit command frame
//   spi_statusreg_o  operation code (8'h02 = single-block read)
//   mem_we_o/mem_addr_o/mem_data_o  target memory write port
//   boot_busy_o/boot_done_o/boot_err_o/err_code_o  status to boot controller
module spi_bootfetch #(
    parameter logic [31:0] START_SECTOR = 32'd0,
    parameter int unsigned NUM_SECTORS  = 16,
    parameter int unsigned MEM_AW       = 12,
    parameter int unsigned TIMEOUT      = 65535
) (
    input  logic              spi_clk_i,
    input  logic              spi_rst_i,
    input  logic              boot_start_i,
    input  logic              spi_initdone_i,
    input  logic [2:0]        spi_flagreg_i,
    input  logic [31:0]       spi_data_i,
    output logic              spi_init_o,
    output logic              spi_enableoper_o,
    output logic [47:0]       spi_cmd_o,
    output logic [7:0]        spi_statusreg_o,
    output logic              mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic              boot_busy_o,
    output logic              boot_done_o,
    output logic              boot_err_o,
    output logic [1:0]        err_code_o
);

    localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
    localparam logic [15:0]   SEC_LAST = 16'(NUM_SECTORS);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_WAIT_INIT, S_CMD, S_WAIT_R1, S_DATA, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       sec_q, sec_d;
    logic [6:0]        wcnt_q, wcnt_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [1:0]        code_q, code_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              init_q, init_d;
    logic              enop_q, enop_d;
    logic [47:0]       cmd_q, cmd_d;
    logic [7:0]        stat_q, stat_d;
    logic              waiting;

    always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
        if (!spi_rst_i) begin
            state_q <= S_IDLE;
            sec_q   <= '0;
            wcnt_q  <= '0;
            addr_q  <= '0;
            tmr_q   <= '0;
            code_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            init_q  <= 1'b0;
            enop_q  <= 1'b0;
            cmd_q   <= '0;
            stat_q  <= '0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            tmr_q   <= tmr_d;
            code_q  <= code_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            init_q  <= init_d;
            enop_q  <= enop_d;
            cmd_q   <= cmd_d;
            stat_q  <= stat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        tmr_d   = tmr_q;
        code_d  = code_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        init_d  = 1'b0;
        enop_d  = 1'b0;
        cmd_d   = cmd_q;
        stat_d  = stat_q;
        waiting = (state_q == S_WAIT_INIT) || (state_q == S_WAIT_R1) || (state_q == S_DATA);

        // Address advances the cycle after the write is presented.
        if (we_q) addr_d = addr_q + 1'b1;
        if (waiting) tmr_d = tmr_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (boot_start_i) begin
                    sec_d   = '0;
                    wcnt_d  = '0;
                    addr_d  = '0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                init_d  = 1'b1;
                state_d = S_WAIT_INIT;
            end
            S_WAIT_INIT: begin
                if (spi_initdone_i) begin
                    state_d = S_CMD;
                end else if (tmr_q == TMR_LAST) begin
                    state_d = S_ERR;
                    code_d  = 2'd2;
                end
            end
            S_CMD: begin
                enop_d  = 1'b1;
                state_d = S_WAIT_R1;
            end
            S_WAIT_R1: begin
                if (spi_flagreg_i[2]) begin
                    state_d = S_ERR;
                    code_d  = 2'd3;
                end else if (spi_flagreg_i[0]) begin
                    tmr_d = '0;
                    if (spi_data_i[7:0] == 8'h00) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_ERR;
                        code_d  = 2'd1;
                    end
                end else if (tmr_q == TMR_LAST) begin
                    state_d = S_ERR;
                    code_d  = 2'd2;
                end
            end
            S_DATA: begin
                if (spi_flagreg_i[2]) begin
                    state_d = S_ERR;
                    code_d  = 2'd3;
                end else if (spi_flagreg_i[1]) begin
                    we_d    = 1'b1;
                    wdata_d = spi_data_i;
                    tmr_d   = '0;
                    wcnt_d  = wcnt_q + 7'd1;
                    if (wcnt_q == 7'd127) state_d = S_NEXT;
                end else if (spi_flagreg_i[0]) begin
                    tmr_d = '0;
                end else if (tmr_q == TMR_LAST) begin
                    state_d = S_ERR;
                    code_d  = 2'd2;
                end
            end
            S_NEXT: begin
                sec_d = sec_q + 16'd1;
                if (sec_d == SEC_LAST) state_d = S_DONE;
                else                   state_d = S_CMD;
            end
            default: ;
        endcase

        if (state_d != state_q) tmr_d = '0;

        // Frame is captured on entry to CMD using the already-advanced sector count.
        if (state_d == S_CMD && state_q != S_CMD) begin
            cmd_d  = {2'b01, 6'd17, START_SECTOR + {16'd0, sec_d}, 8'hFF};
            stat_d = 8'h02;
        end
    end

    assign spi_init_o       = init_q;
    assign spi_enableoper_o = enop_q;
    assign spi_cmd_o        = cmd_q;
    assign spi_statusreg_o  = stat_q;
    assign mem_we_o         = we_q;
    assign mem_addr_o       = addr_q;
    assign mem_data_o       = wdata_q;
    assign err_code_o       = code_q;
    assign boot_busy_o      = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
    assign boot_done_o      = (state_q == S_DONE);
    assign boot_err_o       = (state_q == S_ERR);

endmodule

// File: tb/tb_spi_bootfetch.sv
module tb_spi_bootfetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        initdone;
    logic [2:0]  flag;
    logic [31:0] data;

    logic        init_a, enop_a, we_a, busy_a, done_a, err_a;
    logic [47:0] cmd_a;
    logic [7:0]  stat_a;
    logic [11:0] addr_a;
    logic [31:0] wdat_a;
    logic [1:0]  code_a;

    logic        init_w, enop_w, we_w, busy_w, done_w, err_w;
    logic [47:0] cmd_w;
    logic [7:0]  stat_w;
    logic [6:0]  addr_w;
    logic [31:0] wdat_w;
    logic [1:0]  code_w;

    int total = 0;
    int bad   = 0;
    int wa_addr[$];
    int wa_data[$];
    int ww_addr[$];
    int ww_data[$];
    int n_init = 0;
    int n_enop = 0;

    localparam logic [47:0] FRAME0 = 48'h51_00000064_FF;
    localparam logic [47:0] FRAME1 = 48'h51_00000065_FF;

    spi_bootfetch #(.START_SECTOR(32'd100), .NUM_SECTORS(2), .MEM_AW(12), .TIMEOUT(50)) u_a (
        .spi_clk_i(clk), .spi_rst_i(rst_n), .boot_start_i(start), .spi_initdone_i(initdone),
        .spi_flagreg_i(flag), .spi_data_i(data), .spi_init_o(init_a), .spi_enableoper_o(enop_a),
        .spi_cmd_o(cmd_a), .spi_statusreg_o(stat_a), .mem_we_o(we_a), .mem_addr_o(addr_a),
        .mem_data_o(wdat_a), .boot_busy_o(busy_a), .boot_done_o(done_a), .boot_err_o(err_a),
        .err_code_o(code_a)
    );

    spi_bootfetch #(.START_SECTOR(32'd0), .NUM_SECTORS(2), .MEM_AW(7), .TIMEOUT(50)) u_w (
        .spi_clk_i(clk), .spi_rst_i(rst_n), .boot_start_i(start), .spi_initdone_i(initdone),
        .spi_flagreg_i(flag), .spi_data_i(data), .spi_init_o(init_w), .spi_enableoper_o(enop_w),
        .spi_cmd_o(cmd_w), .spi_statusreg_o(stat_w), .mem_we_o(we_w), .mem_addr_o(addr_w),
        .mem_data_o(wdat_w), .boot_busy_o(busy_w), .boot_done_o(done_w), .boot_err_o(err_w),
        .err_code_o(code_w)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we_a) begin
            wa_addr.push_back(int'(addr_a));
            wa_data.push_back(int'(wdat_a));
        end
        if (we_w) begin
            ww_addr.push_back(int'(addr_w));
            ww_data.push_back(int'(wdat_w));
        end
        if (init_a) n_init++;
        if (enop_a) n_enop++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        initdone = 1'b0;
        flag     = 3'b000;
        data     = '0;
        step(2);
        rst_n = 1'b1;
        step();
    endtask

    task automatic start_boot();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("init_early", 64'(init_a), 64'd0);
        chk("busy_init", 64'(busy_a), 64'd1);
        step();
        chk("init_pulse", 64'(init_a), 64'd1);
        initdone = 1'b1;
    endtask

    task automatic wait_enop(input logic [47:0] frame);
        int k = 0;
        while (enop_a !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        chk("enop_seen", 64'(enop_a), 64'd1);
        chk("cmd_frame", 64'(cmd_a), 64'(frame));
        chk("status", 64'(stat_a), 64'h02);
    endtask

    task automatic send_r1(input logic [7:0] r1);
        flag = 3'b001;
        data = {24'd0, r1};
        step();
        flag = 3'b000;
        data = '0;
    endtask

    task automatic send_words(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            flag = 3'b010;
            data = 32'(base + i);
            step();
        end
        flag = 3'b000;
        data = '0;
    endtask

    initial begin
        int i0, w0, k, e0;
        rst_n    = 1'b0;
        start    = 1'b0;
        initdone = 1'b0;
        flag     = 3'b000;
        data     = '0;
        step(2);

        chk("rst_init", 64'(init_a), 64'd0);
        chk("rst_enop", 64'(enop_a), 64'd0);
        chk("rst_cmd", 64'(cmd_a), 64'd0);
        chk("rst_stat", 64'(stat_a), 64'd0);
        chk("rst_we", 64'(we_a), 64'd0);
        chk("rst_addr", 64'(addr_a), 64'd0);
        chk("rst_data", 64'(wdat_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_err", 64'(err_a), 64'd0);
        chk("rst_code", 64'(code_a), 64'd0);
        rst_n = 1'b1;
        step();

        // Normal two-sector boot; the MEM_AW=7 instance sees the same stimulus and wraps.
        i0 = wa_addr.size();
        w0 = ww_addr.size();
        start_boot();
        wait_enop(FRAME0);
        send_r1(8'h00);
        send_words(0, 128);
        wait_enop(FRAME1);
        send_r1(8'h00);
        send_words(128, 128);
        step(3);
        chk("done_a", 64'(done_a), 64'd1);
        chk("err_a", 64'(err_a), 64'd0);
        chk("busy_done", 64'(busy_a), 64'd0);
        chk("done_w", 64'(done_w), 64'd1);
        chk("nwr_a", 64'(wa_addr.size() - i0), 64'd256);
        chk("nwr_w", 64'(ww_addr.size() - w0), 64'd256);
        for (int i = 0; i < 256 && (i0 + i) < wa_addr.size(); i++) begin
            chk("wr_addr", 64'(wa_addr[i0 + i]), 64'(i));
            chk("wr_data", 64'(wa_data[i0 + i]), 64'(i));
        end
        for (int i = 0; i < 256 && (w0 + i) < ww_addr.size(); i++) begin
            chk("wrap_addr", 64'(ww_addr[w0 + i]), 64'(i % 128));
            chk("wrap_data", 64'(ww_data[w0 + i]), 64'(i));
        end
        k = n_init;
        start = 1'b1;
        step();
        start = 1'b0;
        step(3);
        chk("start_in_done", 64'(n_init - k), 64'd0);
        chk("done_sticky", 64'(done_a), 64'd1);

        // R1 error on the first command
        do_reset();
        i0 = wa_addr.size();
        start_boot();
        wait_enop(FRAME0);
        send_r1(8'h04);
        e0 = n_enop;
        step(2);
        chk("r1_err", 64'(err_a), 64'd1);
        chk("r1_code", 64'(code_a), 64'd1);
        chk("r1_busy", 64'(busy_a), 64'd0);
        send_words(0, 4);
        step(20);
        chk("r1_nowrite", 64'(wa_addr.size() - i0), 64'd0);
        chk("r1_noenop", 64'(n_enop - e0), 64'd0);
        chk("r1_sticky", 64'(err_a), 64'd1);

        // Timeout after the 10th word
        do_reset();
        i0 = wa_addr.size();
        start_boot();
        wait_enop(FRAME0);
        send_r1(8'h00);
        send_words(0, 10);
        step(49);
        chk("to_early", 64'(err_a), 64'd0);
        step();
        chk("to_err", 64'(err_a), 64'd1);
        chk("to_code", 64'(code_a), 64'd2);
        chk("to_addr", 64'(addr_a), 64'd10);
        chk("to_nwr", 64'(wa_addr.size() - i0), 64'd10);

        // flag[2] together with flag[1]
        do_reset();
        i0 = wa_addr.size();
        start_boot();
        wait_enop(FRAME0);
        send_r1(8'h00);
        send_words(0, 3);
        flag = 3'b110;
        data = 32'hDEAD_BEEF;
        step();
        flag = 3'b000;
        data = '0;
        step(3);
        chk("de_err", 64'(err_a), 64'd1);
        chk("de_code", 64'(code_a), 64'd3);
        chk("de_nwr", 64'(wa_addr.size() - i0), 64'd3);
        chk("de_addr", 64'(addr_a), 64'd3);

        // Asynchronous reset in the middle of sector 0, then restart
        do_reset();
        i0 = wa_addr.size();
        start_boot();
        wait_enop(FRAME0);
        send_r1(8'h00);
        send_words(0, 5);
        flag = 3'b010;
        data = 32'd5;
        step();
        flag = 3'b000;
        data = '0;
        chk("mid_we", 64'(we_a), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_we", 64'(we_a), 64'd0);
        chk("arst_addr", 64'(addr_a), 64'd0);
        chk("arst_busy", 64'(busy_a), 64'd0);
        chk("arst_cmd", 64'(cmd_a), 64'd0);
        chk("arst_stat", 64'(stat_a), 64'd0);
        chk("arst_data", 64'(wdat_a), 64'd0);
        step(2);
        rst_n = 1'b1;
        step();
        chk("arst_nwr", 64'(wa_addr.size() - i0), 64'd5);
        k  = n_init;
        i0 = wa_addr.size();
        start_boot();
        step();
        chk("restart_init", 64'(n_init - k), 64'd1);
        wait_enop(FRAME0);
        send_r1(8'h00);
        send_words(100, 8);
        step(2);
        chk("restart_nwr", 64'(wa_addr.size() - i0), 64'd8);
        if (wa_addr.size() - i0 == 8) begin
            chk("restart_addr0", 64'(wa_addr[i0]), 64'd0);
            chk("restart_data0", 64'(wa_data[i0]), 64'd100);
            chk("restart_addr7", 64'(wa_addr[i0 + 7]), 64'd7);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_bootfetch.md
# spi_bootfetch

Boot-image fetch sequencer that sits directly upstream of the microSDHC SPI core and consumes its outputs. After a start request it runs card initialisation, issues one CMD17 (READ_SINGLE_BLOCK) per sector, and collects the 32-bit words returned by the core into a target memory through a write port. It reports completion or a coded error to the boot controller.

## Interface
Parameters:
- START_SECTOR, 0: first SDHC block address read (block addressing, 512 B per block).
- NUM_SECTORS, 16: number of consecutive sectors fetched; legal range 1..65535.
- MEM_AW, 12: word-address width of the target memory.
- TIMEOUT, 65535: maximum idle cycles allowed while waiting on the core.

Ports:
- spi_clk_i  in  1  system clock; all logic is on the rising edge.
- spi_rst_i  in  1  asynchronous, active-low reset.
- boot_start_i  in  1  start pulse; sampled only in IDLE.
- spi_initdone_i  in  1  card initialisation complete (level).
- spi_flagreg_i  in  3  [0] R1 response valid, [1] data word valid, [2] core data error; each is a one-cycle strobe.
- spi_data_i  in  32  word from the core; bits [7:0] carry R1 when flag[0] is high.
- spi_init_o  out  1  one-cycle pulse that starts card initialisation.
- spi_enableoper_o  out  1  one-cycle pulse that launches the command on spi_cmd_o.
- spi_cmd_o  out  48  command frame.
- spi_statusreg_o  out  8  operation code; 8'h02 means single-block read.
- mem_we_o  out  1  memory write strobe.
- mem_addr_o  out  MEM_AW  memory word address.
- mem_data_o  out  32  memory write data.
- boot_busy_o  out  1  sequence is in progress.
- boot_done_o  out  1  all sectors have been stored (sticky).
- boot_err_o  out  1  error has occurred (sticky).
- err_code_o  out  2  1 = R1 nonzero, 2 = timeout, 3 = core data error.

## Operation
- States: IDLE, INIT, WAIT_INIT, CMD, WAIT_R1, DATA, NEXT, DONE, ERR.
- IDLE: when boot_start_i is high, clear the sector counter, word counter and mem address, then go to INIT.
- INIT: assert spi_init_o for one cycle, then go to WAIT_INIT.
- WAIT_INIT: when spi_initdone_i is high, go to CMD.
- CMD: assert spi_enableoper_o for one cycle, then go to WAIT_R1.
  - spi_cmd_o = {2'b01, 6'd17, START_SECTOR + sector_cnt (32 b, mod 2^32), 8'hFF}.
  - spi_statusreg_o = 8'h02.
  - spi_cmd_o and spi_statusreg_o are registered when entering CMD and held stable until NEXT.
- WAIT_R1: on flag[0], R1 = spi_data_i[7:0]. R1 == 0 goes to DATA; any other value goes to ERR with code 1.
- DATA: each flag[1] strobe writes one word. After the 128th word of the sector, go to NEXT.
- NEXT: increment sector_cnt. If sector_cnt equals NUM_SECTORS, go to DONE; otherwise go to CMD.
- DONE and ERR are terminal. boot_done_o or boot_err_o stays high until reset. boot_start_i is ignored in these states.
- Timeout counter:
  - Runs in WAIT_INIT, WAIT_R1 and DATA.
  - Clears on state entry and on every flag[0] or flag[1] strobe.
  - Reaching TIMEOUT goes to ERR with code 2.
- flag[2] in WAIT_R1 or DATA goes to ERR with code 3. It has priority over flag[0] and flag[1] in the same cycle.
- Flags arriving in any other state are ignored.
- mem_addr_o increments after every write and wraps modulo 2^MEM_AW with no error. The image size NUM_SECTORS*128 is the integrator's responsibility.

## Timing
- Reset values: every output is 0, except spi_cmd_o = 48'h0 and spi_statusreg_o = 8'h00; state is IDLE.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). Any in-flight write is dropped.
- boot_start_i high in cycle t: spi_init_o is high in cycle t+2 (IDLE→INIT transition, then registered output).
- Data word strobe in cycle t:
  - mem_we_o, mem_data_o and mem_addr_o are valid in cycle t+1.
  - mem_addr_o increments in cycle t+2.
  - Back-to-back strobes on every cycle are supported.
- mem_we_o is never high outside the cycle after an accepted strobe.
- spi_enableoper_o for sector k+1 comes no earlier than 2 cycles after the last word of sector k.
- boot_busy_o is high in every state except IDLE, DONE and ERR.

## Test plan
- Normal boot, NUM_SECTORS=2, START_SECTOR=100, R1=0, 256 words with data = index:
  - two commands, frames 48'h51_00000064_FF and 48'h51_00000065_FF;
  - 256 writes at addresses 0..255 with data matching the index;
  - boot_done_o=1, boot_err_o=0.
- R1 = 8'h04 on the first command: no mem_we_o, boot_err_o=1, err_code_o=1, spi_enableoper_o never pulses again.
- Timeout, TIMEOUT=50, no flag after the 10th word: ERR with code 2 exactly 50 cycles after the 10th strobe; mem_addr_o = 10.
- flag[1] and flag[2] in the same cycle in DATA: no write for that word; err_code_o=3.
- Reset asserted in the middle of sector 0, then boot_start_i again: all outputs go to 0 asynchronously; the restart reissues spi_init_o and writes again from address 0.
- MEM_AW=7, NUM_SECTORS=2: the 129th word is written to address 0 (wrap); boot_done_o=1.
